// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the core and a slow block memory.
// Define DCACHE_STATS_EN to add the stat_hits / stat_misses counters.
module dcache_wb_dm #(
   parameter int INDEX_W = 3,
   parameter int ADDR_W  = 30
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                proc_read,
   input  logic                proc_write,
   input  logic [ADDR_W-1:0]   proc_addr,
   input  logic [31:0]         proc_wdata,
   output logic [31:0]         proc_rdata,
   output logic                proc_stall,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-3:0]   mem_addr,
   output logic [127:0]        mem_wdata,
   input  logic [127:0]        mem_rdata,
   input  logic                mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]         stat_hits,
   output logic [31:0]         stat_misses
`endif
);

   localparam int TAG_W = ADDR_W - INDEX_W - 2;
   localparam int NB    = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t                 state_r;
   logic [NB-1:0]          valid_r;
   logic [NB-1:0]          dirty_r;
   logic [TAG_W-1:0]       tag_r  [NB];
   logic [3:0][31:0]       data_r [NB];

   logic [INDEX_W-1:0]     idx_s;
   logic [1:0]             off_s;
   logic [TAG_W-1:0]       tag_s;
   logic                   req_s;
   logic                   hit_s;
   logic                   fill_s;
   logic                   store_s;

   assign idx_s = proc_addr[INDEX_W+1:2];
   assign off_s = proc_addr[1:0];
   assign tag_s = proc_addr[ADDR_W-1:INDEX_W+2];
   assign req_s = proc_read | proc_write;

   // Lookup, stall and load data; a simultaneous read+write is a store, so no load data.
   always_comb begin
      hit_s      = 1'b0;
      proc_rdata = 32'd0;
      fill_s     = 1'b0;
      store_s    = 1'b0;
      if ((state_r == IDLE) && valid_r[idx_s] && (tag_r[idx_s] == tag_s)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
      proc_stall = req_s & ~hit_s;
      if (proc_read && !proc_write && hit_s) begin
         proc_rdata = data_r[idx_s][off_s];
      end else begin
         proc_rdata = 32'd0;
      end
      if (rst_n && (state_r == ALLOCATE) && mem_ready) begin
         fill_s = 1'b1;
      end else begin
         fill_s = 1'b0;
      end
      if (rst_n && hit_s && proc_write) begin
         store_s = 1'b1;
      end else begin
         store_s = 1'b0;
      end
   end

   // Tag and data arrays: refill a whole block or merge one stored word; never reset.
   always_ff @(posedge clk) begin
      if (fill_s) begin
         data_r[idx_s] <= mem_rdata;
         tag_r[idx_s]  <= tag_s;
      end else if (store_s) begin
         data_r[idx_s][off_s] <= proc_wdata;
      end
   end

   // Miss FSM with registered memory-side outputs; tag/index always come from the live request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         valid_r   <= '0;
         dirty_r   <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 128'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_s && hit_s) begin
                  if (proc_write) begin
                     dirty_r[idx_s] <= 1'b1;
                  end
               end else if (req_s) begin
                  if (valid_r[idx_s] && dirty_r[idx_s]) begin
                     state_r   <= WRITEBACK;
                     mem_write <= 1'b1;
                     mem_addr  <= {tag_r[idx_s], idx_s};
                     mem_wdata <= data_r[idx_s];
                  end else begin
                     state_r  <= ALLOCATE;
                     mem_read <= 1'b1;
                     mem_addr <= {tag_s, idx_s};
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  state_r        <= ALLOCATE;
                  mem_write      <= 1'b0;
                  mem_read       <= 1'b1;
                  mem_addr       <= {tag_s, idx_s};
                  dirty_r[idx_s] <= 1'b0;
               end
            end
            ALLOCATE: begin
               if (mem_ready) begin
                  state_r        <= IDLE;
                  mem_read       <= 1'b0;
                  valid_r[idx_s] <= 1'b1;
                  dirty_r[idx_s] <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   // Hit/miss counters; a miss is counted only on its IDLE cycle, the post-fill cycle counts as a hit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_hits   <= 32'd0;
         stat_misses <= 32'd0;
      end else if (state_r == IDLE) begin
         if (req_s && hit_s) begin
            stat_hits <= stat_hits + 32'd1;
         end else if (req_s) begin
            stat_misses <= stat_misses + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed self-checking bench for dcache_wb_dm with a behavioural block memory.
// Checks the stat counters too when DCACHE_STATS_EN is defined.
module tb_dcache_wb_dm;

   logic          clk;
   logic          rst_n;
   logic          proc_read;
   logic          proc_write;
   logic [29:0]   proc_addr;
   logic [31:0]   proc_wdata;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          mem_read;
   logic          mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata;
   logic          mem_ready;
`ifdef DCACHE_STATS_EN
   logic [31:0]   stat_hits;
   logic [31:0]   stat_misses;
`endif

   dcache_wb_dm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .stat_hits  (stat_hits),
      .stat_misses(stat_misses)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [127:0] mem_m [logic [27:0]];
   int           lat = 3;
   int           busy = 0;
   int           seq = 0;
   int           rd_cycles, wr_cycles, both, first_rd, first_wr;
   logic [27:0]  rd_addr, wr_addr;
   logic [127:0] wr_data;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      rd_cycles = 0; wr_cycles = 0; both = 0; first_rd = -1; first_wr = -1;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
   endtask

   // Called once per cycle at the negative edge: models the slow memory with fixed latency.
   task automatic serve_mem();
      seq++;
      mem_ready = 1'b0;
      if (mem_read && mem_write) both++;
      if (mem_read || mem_write) begin
         busy++;
         if (mem_read) begin
            rd_cycles++;
            rd_addr = mem_addr;
            if (first_rd < 0) first_rd = seq;
            mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 128'd0;
         end
         if (mem_write) begin
            wr_cycles++;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
            if (first_wr < 0) first_wr = seq;
         end
         if (busy == lat) begin
            mem_ready = 1'b1;
            busy = 0;
            if (mem_write) mem_m[mem_addr] = mem_wdata;
         end
      end else begin
         busy = 0;
      end
   endtask

   // One processor access held until the stall drops; returns load data and stalled cycle count.
   task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                         input logic [31:0] wd, output logic [31:0] rdata, output int ncyc);
      clear_stats();
      ncyc = 0;
      @(negedge clk);
      proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
      for (int k = 0; k < 60; k++) begin
         serve_mem();
         #1;
         if (!proc_stall) break;
         ncyc++;
         @(negedge clk);
      end
      check_eq("stall_released", 32'(proc_stall), 32'd0);
      rdata = proc_rdata;
      @(posedge clk);
      #1;
      proc_read = 1'b0; proc_write = 1'b0;
   endtask

   logic [31:0] rdata;
   int          ncyc;
`ifdef DCACHE_STATS_EN
   logic [31:0] h0, m0;
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      clear_stats();
      mem_m[28'h4] = 128'h00000044_00000033_00000022_00000011;
      mem_m[28'hC] = 128'hC0000003_C0000002_C0000001_C0000000;
      mem_m[28'h19] = 128'h19000003_19000002_19000001_19000000;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_mem_read", 32'(mem_read), 32'd0);
      check_eq("rst_mem_write", 32'(mem_write), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_mem_wdata", mem_wdata[31:0], 32'd0);
      check_eq("rst_stall", 32'(proc_stall), 32'd0);
      check_eq("rst_rdata", proc_rdata, 32'd0);
`ifdef DCACHE_STATS_EN
      check_eq("rst_stat_hits", stat_hits, 32'd0);
      check_eq("rst_stat_misses", stat_misses, 32'd0);
`endif
      rst_n = 1'b1;

      // Clean miss: fill of block 4 with three mem_read cycles.
      access(1'b1, 1'b0, 30'h10, 32'd0, rdata, ncyc);
      check_eq("miss1_rdata", rdata, 32'h11);
      check_eq("miss1_rd_cycles", 32'(rd_cycles), 32'd3);
      check_eq("miss1_rd_addr", 32'(rd_addr), 32'h4);
      check_eq("miss1_wr_cycles", 32'(wr_cycles), 32'd0);
      check_eq("miss1_latency", 32'(ncyc), 32'd4);

      // Write hit then read hits, no memory traffic.
      access(1'b0, 1'b1, 30'h11, 32'hDEADBEEF, rdata, ncyc);
      check_eq("whit_stall", 32'(ncyc), 32'd0);
      check_eq("whit_rdata_zero", rdata, 32'd0);
      check_eq("whit_traffic", 32'(rd_cycles + wr_cycles), 32'd0);
      access(1'b1, 1'b0, 30'h11, 32'd0, rdata, ncyc);
      check_eq("rhit_rdata", rdata, 32'hDEADBEEF);
      check_eq("rhit_stall", 32'(ncyc), 32'd0);
      check_eq("rhit_traffic", 32'(rd_cycles + wr_cycles), 32'd0);
      access(1'b1, 1'b0, 30'h12, 32'd0, rdata, ncyc);
      check_eq("rhit_other_word", rdata, 32'h33);

      // Dirty eviction of index 4 by tag 1.
      access(1'b1, 1'b0, 30'h30, 32'd0, rdata, ncyc);
      check_eq("evict_rdata", rdata, 32'hC0000000);
      check_eq("evict_wr_cycles", 32'(wr_cycles), 32'd3);
      check_eq("evict_wr_addr", 32'(wr_addr), 32'h4);
      check_eq("evict_wr_word1", wr_data[63:32], 32'hDEADBEEF);
      check_eq("evict_wr_word0", wr_data[31:0], 32'h11);
      check_eq("evict_rd_cycles", 32'(rd_cycles), 32'd3);
      check_eq("evict_rd_addr", 32'(rd_addr), 32'hC);
      check_eq("evict_wb_first", 32'(first_wr < first_rd), 32'd1);
      check_eq("evict_rw_overlap", 32'(both), 32'd0);
      check_eq("evict_latency", 32'(ncyc), 32'd7);

      // Refill of the written-back block: clean victim, data came through memory.
      access(1'b1, 1'b0, 30'h11, 32'd0, rdata, ncyc);
      check_eq("refill_rdata", rdata, 32'hDEADBEEF);
      check_eq("refill_wr_cycles", 32'(wr_cycles), 32'd0);
      check_eq("refill_latency", 32'(ncyc), 32'd4);

      // Read and write together behave as a store.
      access(1'b1, 1'b1, 30'h11, 32'h5, rdata, ncyc);
      check_eq("rw_stall", 32'(ncyc), 32'd0);
      check_eq("rw_rdata_zero", rdata, 32'd0);
      access(1'b1, 1'b0, 30'h11, 32'd0, rdata, ncyc);
      check_eq("rw_readback", rdata, 32'h5);

`ifdef DCACHE_STATS_EN
      h0 = stat_hits; m0 = stat_misses;
      access(1'b1, 1'b0, 30'h64, 32'd0, rdata, ncyc);
      check_eq("stat_fill_rdata", rdata, 32'h19000000);
      access(1'b1, 1'b0, 30'h64, 32'd0, rdata, ncyc);
      access(1'b1, 1'b0, 30'h65, 32'd0, rdata, ncyc);
      check_eq("stat_hit_rdata", rdata, 32'h19000001);
      check_eq("stat_misses_delta", stat_misses - m0, 32'd1);
      check_eq("stat_hits_delta", stat_hits - h0, 32'd3);
`endif

      // Reset asserted while ALLOCATE is waiting for memory.
      clear_stats();
      @(negedge clk);
      proc_read = 1'b1; proc_addr = 30'h40;
      serve_mem();
      #1;
      check_eq("rstalloc_stall", 32'(proc_stall), 32'd1);
      @(negedge clk);
      serve_mem();
      #1;
      check_eq("rstalloc_mem_read", 32'(mem_read), 32'd1);
      check_eq("rstalloc_mem_addr", 32'(mem_addr), 32'h10);
      rst_n = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check_eq("rstalloc_read_drop", 32'(mem_read), 32'd0);
      check_eq("rstalloc_write_drop", 32'(mem_write), 32'd0);
      check_eq("rstalloc_idle_miss", 32'(proc_stall), 32'd1);
      rst_n = 1'b1; proc_read = 1'b0; busy = 0;
      @(negedge clk);

      // All blocks invalid: the dirty store of 0x5 is lost, memory still has DEADBEEF.
      access(1'b1, 1'b0, 30'h11, 32'd0, rdata, ncyc);
      check_eq("post_rst_rdata", rdata, 32'hDEADBEEF);
      check_eq("post_rst_rd_cycles", 32'(rd_cycles), 32'd3);
      check_eq("post_rst_wr_cycles", 32'(wr_cycles), 32'd0);
      access(1'b1, 1'b0, 30'h40, 32'd0, rdata, ncyc);
      check_eq("post_rst_remiss", 32'(ncyc), 32'd4);
      check_eq("post_rst_remiss_addr", 32'(rd_addr), 32'h10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
